fpro_mmio_arbiter: RTL
======================

# fpro_mmio_arbiter

Two-master arbiter for the FPro MMIO bus. It sits between two bus masters and the single `mmio_cs/mmio_wr/mmio_rd` port of the MMIO subsystem:
- M0 is the CPU.
- M1 is a secondary engine, for example a DMA or debug bridge.

Each master presents a latched request. The arbiter grants one master at a time using round-robin, issues exactly one single-cycle bus access, captures read data, and returns a one-cycle acknowledge to the winning master.

## Interface
- `ADDR_W`, default 21: MMIO address width; matches `mmio_addr`.
- `DATA_W`, default 32: MMIO data width.

- `clk`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_req` / `m1_req`  in  1  request, level; held until the matching ack.
- `m0_wr` / `m1_wr`  in  1  write command, valid with req.
- `m0_rd` / `m1_rd`  in  1  read command, valid with req.
- `m0_addr` / `m1_addr`  in  ADDR_W  target address, valid with req.
- `m0_wr_data` / `m1_wr_data`  in  DATA_W  write data, valid with req.
- `m0_lock` / `m1_lock`  in  1  bus-hold request; used only when the lock feature is compiled in.
- `m0_ack` / `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rd_data` / `m1_rd_data`  out  DATA_W  read result; valid during ack, held until the next ack to that master.
- `mmio_cs`  out  1  bus select, one cycle per transaction.
- `mmio_wr` / `mmio_rd`  out  1  bus strobes.
- `mmio_addr`  out  ADDR_W  bus address.
- `mmio_wr_data`  out  DATA_W  bus write data.
- `mmio_rd_data`  in  DATA_W  bus read data; combinational from the slot in the `mmio_cs` cycle.
- `busy`  out  1  high in ISSUE and DONE.

## Operation
The state machine has three states: IDLE, ISSUE, DONE.

- **IDLE**
  - Sample `m0_req`/`m1_req`.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the master that was not granted last (`last_gnt`); `last_gnt` resets to 1, so M0 wins the first tie.
  - On grant, register `wr`, `rd`, `addr` and `wr_data` from the winner, record the owner, and go to ISSUE.
- **ISSUE**
  - Drive `mmio_cs`=1 and `mmio_addr`/`mmio_wr_data` from the registers.
  - `mmio_wr` = latched wr.
  - `mmio_rd` = latched rd & ~wr; write wins if both are set.
  - If neither is set, assert `mmio_cs` alone.
  - Capture `mmio_rd_data` into the owner's `rd_data` register at the end of the cycle, for reads only.
  - Go to DONE.
- **DONE**
  - Pulse the owner's ack.
  - Update `last_gnt` to the owner.
  - Go to IDLE.
- The non-owner's `rd_data` and ack are never disturbed.
- In every cycle outside ISSUE, `mmio_cs`, `mmio_wr` and `mmio_rd` are 0, and `mmio_addr`/`mmio_wr_data` are 0.
- Master obligations:
  - Command fields must stay stable from req assertion until ack.
  - Deassert req on the edge that ends the ack cycle, or keep it high to queue the next transaction.
  - A req still high in IDLE after an ack is treated as a new request.

## Timing
- Reset values: all outputs 0, state IDLE, `last_gnt`=1, `rd_data` registers 0, lock-hold flag 0.
- Reset is asynchronous: outputs clear immediately when `reset_n` falls.
  - An in-flight transaction is aborted with no ack.
  - `mmio_cs` drops mid-cycle; the slot write strobe is lost.
- Latency: req seen in IDLE cycle T → `mmio_cs` in T+1 → ack in T+2.
- Throughput: one transaction per 3 cycles.
- Fairness: with both masters holding req continuously, grants alternate M0, M1, M0, …, so each master gets one transaction per 6 cycles.
- A req that rises during ISSUE/DONE is not seen until the next IDLE.

## Configuration
- Macro: `FPRO_ARB_LOCK_EN`.
- **Defined:**
  - If the owner's lock is high in the DONE cycle, a hold flag is set.
  - In the next IDLE, the owner is granted regardless of the other req and round-robin.
  - `last_gnt` still updates, so the other master wins first once the hold ends.
  - The hold ends as soon as the owner's req is low in IDLE; the other master then arbitrates normally that cycle.
  - Lock with no req has no effect.
- **Undefined:**
  - `m0_lock`/`m1_lock` are present but ignored.
  - Arbitration is pure round-robin.

## Test plan
- M0 write alone: `addr`=0x000C0, `wr_data`=0xA5A5_0001 → `mmio_cs`=`mmio_wr`=1 with those values exactly in T+1; `m0_ack` in T+2; `busy` high T+1..T+2.
- M1 read alone, slot returns 0x0000_FFFF → `mmio_rd`=1 in T+1; `m1_rd_data`=0x0000_FFFF with `m1_ack` in T+2; `m0_rd_data` stays 0.
- Both req from reset, each doing 3 writes → bus owner order M0, M1, M0, M1, M0, M1; acks at cycles 2, 5, 8, 11, 14, 17.
- Req with both wr and rd set → `mmio_wr`=1, `mmio_rd`=0; ack still pulses.
- `reset_n` pulled low during ISSUE → `mmio_cs` drops immediately, no ack; after release, a tie grants M0.
- With `FPRO_ARB_LOCK_EN`: M1 holds lock and req for 3 transactions while M0 requests → three consecutive M1 acks, then M0 is granted in the IDLE after M1 drops req. Without the macro, the same stimulus alternates M1, M0, M1.

Source files
------------

// File: rtl/fpro_mmio_arbiter.sv
// fpro_mmio_arbiter: two-master round-robin arbiter driving one single-cycle MMIO access per grant.
// Define FPRO_ARB_LOCK_EN to let the current owner keep the bus across transactions via m*_lock.
module fpro_mmio_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic              m0_lock,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m1_lock,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t state, state_nx;
    logic owner, last_gnt, wr_q, rd_q, any_req, gnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wr_data_q;

    assign any_req = m0_req | m1_req;

`ifdef FPRO_ARB_LOCK_EN
    logic hold, owner_req;
    assign owner_req = owner ? m1_req : m0_req;
    // A held owner wins while it keeps requesting; once it lets go, normal round-robin applies.
    assign gnt = (hold & owner_req) ? owner : (m0_req & m1_req) ? ~last_gnt : m1_req;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            hold <= 1'b0;
        else if (state == DONE)
            hold <= owner ? m1_lock : m0_lock;
        else if (state == IDLE && !owner_req)
            hold <= 1'b0;
`else
    logic lock_unused;
    assign lock_unused = m0_lock ^ m1_lock;
    assign gnt = (m0_req & m1_req) ? ~last_gnt : m1_req;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? (any_req ? ISSUE : IDLE) : (state == ISSUE) ? DONE : IDLE;

    always_comb begin
        mmio_cs      = state == ISSUE;
        mmio_wr      = mmio_cs & wr_q;
        mmio_rd      = mmio_cs & rd_q & ~wr_q;
        mmio_addr    = mmio_cs ? addr_q : '0;
        mmio_wr_data = mmio_cs ? wr_data_q : '0;
        m0_ack       = state == DONE && !owner;
        m1_ack       = state == DONE && owner;
        busy         = state != IDLE;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            owner      <= 1'b0;
            last_gnt   <= 1'b1;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            m0_rd_data <= '0;
            m1_rd_data <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner     <= gnt;
                wr_q      <= gnt ? m1_wr : m0_wr;
                rd_q      <= gnt ? m1_rd : m0_rd;
                addr_q    <= gnt ? m1_addr : m0_addr;
                wr_data_q <= gnt ? m1_wr_data : m0_wr_data;
            end
            if (state == ISSUE && rd_q && !wr_q) begin
                if (owner)
                    m1_rd_data <= mmio_rd_data;
                else
                    m0_rd_data <= mmio_rd_data;
            end
            if (state == DONE)
                last_gnt <= owner;
        end
endmodule
